// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode pipeline definitions for the instruction queue.
package inst_queue_pkg;

   localparam int unsigned IQ_XLEN = 32;
   localparam logic [IQ_XLEN-1:0] IQ_NOP = 32'h0000_0000;

   typedef struct packed {
      logic [IQ_XLEN-1:0] pc;
      logic [IQ_XLEN-1:0] inst;
   } iq_entry;

endpackage

// File: rtl/iq_ram.sv
// Instruction queue storage: DEPTH x {pc, inst}, synchronous write, asynchronous read.
// Storage is deliberately not reset; validity is tracked by the queue's occupancy count.
module iq_ram
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 1
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  iq_entry       wdata_i,
   input  logic [AW-1:0] raddr_i,
   output iq_entry       rdata_o
);

   iq_entry mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode circular FIFO: 1-cycle minimum latency, no fall-through, 1 inst/cycle.
// Pause is raised while full; a flush empties the queue and wins over push/pop.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned        DEPTH = 2,
   parameter int unsigned        AW    = 1,
   parameter logic [IQ_XLEN-1:0] NOP   = IQ_NOP
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_IQ_valid,
   input  logic [IQ_XLEN-1:0] i_IQ_inst,
   input  logic [IQ_XLEN-1:0] i_IQ_PC,
   output logic               o_IQ_pause,
   input  logic               i_IQ_flush,
   output logic               o_ID_valid,
   output logic [IQ_XLEN-1:0] o_ID_inst,
   output logic [IQ_XLEN-1:0] o_ID_PC,
   input  logic               i_ID_ready,
   output logic [AW:0]        o_IQ_count
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full, empty, push, pop;
   iq_entry       wr_entry, head_entry;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign push  = i_IQ_valid & ~full;
   assign pop   = ~empty & i_ID_ready;

   assign wr_entry.pc   = i_IQ_PC;
   assign wr_entry.inst = i_IQ_inst;

   iq_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_iq_ram (
      .clk     (clk),
      .we_i    (push & ~i_IQ_flush),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_entry)
   );

   // DEPTH is a power of two, so pointer wrap is plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_IQ_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign o_IQ_pause = full;
   assign o_ID_valid = ~empty;
   assign o_IQ_count = count_q;
   assign o_ID_inst  = empty ? NOP : head_entry.inst;
   assign o_ID_PC    = empty ? '0  : head_entry.pc;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) count_q <= DEPTH_C);
   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) pop |-> (count_q != '0));

endmodule

// File: tb/tb_inst_queue.sv
// Directed scenario bench for inst_queue (DEPTH=2).
module tb_inst_queue;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_IQ_valid;
   logic [31:0] i_IQ_inst;
   logic [31:0] i_IQ_PC;
   logic        o_IQ_pause;
   logic        i_IQ_flush;
   logic        o_ID_valid;
   logic [31:0] o_ID_inst;
   logic [31:0] o_ID_PC;
   logic        i_ID_ready;
   logic [1:0]  o_IQ_count;

   int n_pass  = 0;
   int n_total = 0;

   inst_queue #(.DEPTH(2), .AW(1), .NOP(32'h0)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_IQ_valid (i_IQ_valid),
      .i_IQ_inst  (i_IQ_inst),
      .i_IQ_PC    (i_IQ_PC),
      .o_IQ_pause (o_IQ_pause),
      .i_IQ_flush (i_IQ_flush),
      .o_ID_valid (o_ID_valid),
      .o_ID_inst  (o_ID_inst),
      .o_ID_PC    (o_ID_PC),
      .i_ID_ready (i_ID_ready),
      .o_IQ_count (o_IQ_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rstn = 1'b0; i_IQ_valid = 1'b1; i_IQ_inst = 32'hDEAD_BEEF; i_IQ_PC = 32'h40;
      i_IQ_flush = 1'b0; i_ID_ready = 1'b0;
      tick(); tick();
      n_total++; if (o_ID_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_ID_valid); else n_pass++;
      n_total++; if (o_ID_inst !== 32'h0) $display("FAIL reset_inst got %h want 0", o_ID_inst); else n_pass++;
      n_total++; if (o_ID_PC !== 32'h0) $display("FAIL reset_pc got %h want 0", o_ID_PC); else n_pass++;
      n_total++; if (o_IQ_pause !== 1'b0) $display("FAIL reset_pause got %b want 0", o_IQ_pause); else n_pass++;
      n_total++; if (o_IQ_count !== 2'd0) $display("FAIL reset_count got %0d want 0", o_IQ_count); else n_pass++;
      i_IQ_valid = 1'b0;
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      i_IQ_valid = 1'b1; i_IQ_PC = 32'h00; i_IQ_inst = 32'h2008_0001;
      tick();
      n_total++; if (o_IQ_count !== 2'd1) $display("FAIL fill1_count got %0d want 1", o_IQ_count); else n_pass++;
      n_total++; if (o_ID_PC !== 32'h00) $display("FAIL fill1_head_pc got %h want 0", o_ID_PC); else n_pass++;
      i_IQ_PC = 32'h04; i_IQ_inst = 32'h2009_0002;
      tick();
      n_total++; if (o_IQ_count !== 2'd2) $display("FAIL fill2_count got %0d want 2", o_IQ_count); else n_pass++;
      n_total++; if (o_IQ_pause !== 1'b1) $display("FAIL fill2_pause got %b want 1", o_IQ_pause); else n_pass++;
      i_IQ_PC = 32'h08; i_IQ_inst = 32'h200A_0003;
      tick();
      n_total++; if (o_IQ_count !== 2'd2) $display("FAIL full_push_count got %0d want 2", o_IQ_count); else n_pass++;
      n_total++; if (o_ID_PC !== 32'h00) $display("FAIL full_head_pc got %h want 0", o_ID_PC); else n_pass++;
      n_total++; if (o_ID_inst !== 32'h2008_0001) $display("FAIL full_head_inst got %h want 20080001", o_ID_inst); else n_pass++;
      i_IQ_valid = 1'b0;
   endtask

   task automatic test_drain();
      i_ID_ready = 1'b1;
      n_total++; if (o_ID_PC !== 32'h00) $display("FAIL drain0_pc got %h want 0", o_ID_PC); else n_pass++;
      tick();
      n_total++; if (o_ID_PC !== 32'h04) $display("FAIL drain1_pc got %h want 4", o_ID_PC); else n_pass++;
      n_total++; if (o_ID_inst !== 32'h2009_0002) $display("FAIL drain1_inst got %h want 20090002", o_ID_inst); else n_pass++;
      n_total++; if (o_IQ_pause !== 1'b0) $display("FAIL drain1_pause got %b want 0", o_IQ_pause); else n_pass++;
      tick();
      n_total++; if (o_ID_valid !== 1'b0) $display("FAIL drain2_valid got %b want 0", o_ID_valid); else n_pass++;
      n_total++; if (o_IQ_count !== 2'd0) $display("FAIL drain2_count got %0d want 0", o_IQ_count); else n_pass++;
      n_total++; if (o_ID_inst !== 32'h0) $display("FAIL drain2_nop got %h want 0", o_ID_inst); else n_pass++;
      tick();
      n_total++; if (o_IQ_count !== 2'd0) $display("FAIL empty_pop_count got %0d want 0", o_IQ_count); else n_pass++;
      i_ID_ready = 1'b0;
   endtask

   task automatic test_stream();
      i_IQ_valid = 1'b1; i_IQ_PC = 32'h00; i_IQ_inst = 32'h1000_0000;
      tick();
      i_ID_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_total++;
         if (o_ID_PC !== 32'(4 * i) || o_ID_inst !== 32'h1000_0000 + 32'(i))
            $display("FAIL stream_head[%0d] got pc %h inst %h want pc %h inst %h",
                     i, o_ID_PC, o_ID_inst, 32'(4 * i), 32'h1000_0000 + 32'(i));
         else n_pass++;
         n_total++; if (o_IQ_count !== 2'd1) $display("FAIL stream_count[%0d] got %0d want 1", i, o_IQ_count); else n_pass++;
         i_IQ_PC = 32'(4 * (i + 1)); i_IQ_inst = 32'h1000_0000 + 32'(i + 1);
         tick();
      end
      n_total++; if (o_ID_PC !== 32'h28) $display("FAIL stream_tail_pc got %h want 28", o_ID_PC); else n_pass++;
      i_IQ_valid = 1'b0;
      tick();
      n_total++; if (o_IQ_count !== 2'd0) $display("FAIL stream_end_count got %0d want 0", o_IQ_count); else n_pass++;
      i_ID_ready = 1'b0;
   endtask

   task automatic test_flush();
      i_IQ_valid = 1'b1; i_IQ_PC = 32'h100; i_IQ_inst = 32'h3000_0001;
      tick();
      n_total++; if (o_IQ_count !== 2'd1) $display("FAIL preflush_count got %0d want 1", o_IQ_count); else n_pass++;
      i_IQ_flush = 1'b1; i_ID_ready = 1'b1; i_IQ_PC = 32'h104; i_IQ_inst = 32'h3000_0002;
      tick();
      i_IQ_flush = 1'b0; i_IQ_valid = 1'b0; i_ID_ready = 1'b0;
      n_total++; if (o_IQ_count !== 2'd0) $display("FAIL flush_count got %0d want 0", o_IQ_count); else n_pass++;
      n_total++; if (o_ID_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", o_ID_valid); else n_pass++;
      tick();
      n_total++; if (o_ID_valid !== 1'b0 || o_ID_PC !== 32'h0)
         $display("FAIL flush_dropped got valid %b pc %h want valid 0 pc 0", o_ID_valid, o_ID_PC); else n_pass++;
   endtask

   task automatic test_async_reset();
      i_IQ_valid = 1'b1; i_IQ_PC = 32'h200; i_IQ_inst = 32'h4000_0001;
      tick();
      i_IQ_PC = 32'h204; i_IQ_inst = 32'h4000_0002;
      tick();
      i_IQ_valid = 1'b0;
      n_total++; if (o_IQ_count !== 2'd2) $display("FAIL prerst_count got %0d want 2", o_IQ_count); else n_pass++;
      #1 rstn = 1'b0;
      #1;
      n_total++; if (o_IQ_count !== 2'd0) $display("FAIL arst_count got %0d want 0", o_IQ_count); else n_pass++;
      n_total++; if (o_ID_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", o_ID_valid); else n_pass++;
      n_total++; if (o_IQ_pause !== 1'b0) $display("FAIL arst_pause got %b want 0", o_IQ_pause); else n_pass++;
      n_total++; if (o_ID_PC !== 32'h0) $display("FAIL arst_pc got %h want 0", o_ID_PC); else n_pass++;
      #1 rstn = 1'b1;
      i_IQ_valid = 1'b1; i_IQ_PC = 32'h300; i_IQ_inst = 32'h5000_0001;
      #1;
      n_total++; if (o_ID_valid !== 1'b0) $display("FAIL no_fallthrough got %b want 0", o_ID_valid); else n_pass++;
      tick();
      i_IQ_valid = 1'b0;
      n_total++; if (o_ID_valid !== 1'b1 || o_ID_PC !== 32'h300 || o_ID_inst !== 32'h5000_0001)
         $display("FAIL post_rst_head got valid %b pc %h inst %h want 1 300 50000001", o_ID_valid, o_ID_PC, o_ID_inst);
      else n_pass++;
      n_total++; if (o_IQ_count !== 2'd1) $display("FAIL post_rst_count got %0d want 1", o_IQ_count); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
